// File: rtl/wiegand_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wiegand_pkg
// Brief    : Shared frame-length constants, FSM encoding and timing helper
// Revision : 1.0 - initial release
// ============================================================================
package wiegand_pkg;

    localparam int W26 = 26;
    localparam int W34 = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Multiply before dividing so non-integer-MHz clocks keep their precision.
    function automatic int us_to_cycles(input longint clk_hz, input longint us);
        longint v;
        v = (clk_hz * us) / 64'sd1000000;
        return (v < 64'sd1) ? 1 : int'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wiegand_rx_param_if.sv
`default_nettype none
// ============================================================================
// Interface : wiegand_rx_param_if
// Brief     : Frame presentation bus between the receiver and the CPU side
// Revision  : 1.0 - initial release
// ============================================================================
interface wiegand_rx_param_if #(
    parameter int MAX_BITS = 34
) ();

    logic [MAX_BITS-1:0] data;
    logic [6:0]          bit_cnt;
    logic                frame_valid;
    logic                frame_ack;
    logic                parity_ok;
    logic                len_err;
    logic                line_err;
    logic                overrun;
    logic                busy;

    modport master (
        output data, bit_cnt, frame_valid, parity_ok, len_err, line_err, overrun, busy,
        input  frame_ack
    );

    modport slave (
        input  data, bit_cnt, frame_valid, parity_ok, len_err, line_err, overrun, busy,
        output frame_ack
    );

endinterface
`default_nettype wire

// File: rtl/wiegand_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : wiegand_line_filter
// Brief    : Two-flop synchroniser and low-pulse width filter for one line
// Revision : 1.0 - initial release
// ============================================================================
module wiegand_line_filter #(
    parameter int FILT_CYC = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic line_n,
    output logic line_low,
    output logic filt_low,
    output logic pulse_end
);

    localparam int                c_cnt_w     = $clog2(FILT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_filt_last = c_cnt_w'(FILT_CYC - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= line_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != c_filt_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Qualifies on the FILT_CYC-th low cycle so a pulse of exactly FILT_CYC passes.
    assign line_low  = ~r_sync2;
    assign filt_low  = ~r_sync2 & (r_cnt == c_filt_last);
    assign pulse_end = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/wiegand_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : wiegand_rx_param
// Brief    : Parametrised Wiegand receiver with filtering, timeout and parity
// Revision : 1.0 - initial release
// ============================================================================
module wiegand_rx_param
    import wiegand_pkg::*;
#(
    parameter int CLK_HZ     = 1000000,
    parameter int MAX_BITS   = 34,
    parameter int MIN_BITS   = 26,
    parameter int FILT_US    = 20,
    parameter int TIMEOUT_US = 5000,
    parameter int PARITY_EN  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               d0_n,
    input  logic               d1_n,
    wiegand_rx_param_if.master bus
);

    localparam int                c_filt_cyc = us_to_cycles(longint'(CLK_HZ), longint'(FILT_US));
    localparam int                c_to_cyc   = us_to_cycles(longint'(CLK_HZ), longint'(TIMEOUT_US));
    localparam int                c_to_w     = $clog2(c_to_cyc + 1);
    localparam logic [c_to_w-1:0] c_to_last  = c_to_w'(c_to_cyc - 1);
    localparam logic [6:0]        c_max_cnt  = 7'(MAX_BITS);
    localparam logic [6:0]        c_cnt_sat  = 7'(MAX_BITS + 1);
    localparam logic [6:0]        c_min_cnt  = 7'(MIN_BITS);

    logic w_d0_low, w_d0_filt, w_d0_end;
    logic w_d1_low, w_d1_filt, w_d1_end;
    logic w_any_low, w_both_low, w_all_high, w_pulse_end;

    state_t w_state_nxt;
    state_t r_state;
    logic   w_latch;
    logic   w_shift;

    logic [c_to_w-1:0]   r_to_cnt;
    logic                r_latched;
    logic                r_bit;
    logic                r_ignore;
    logic [MAX_BITS-1:0] r_buf;
    logic [6:0]          r_bit_cnt;
    logic                r_len_over;
    logic                r_line_err_acc;

    logic [MAX_BITS-1:0] r_data;
    logic [6:0]          r_cnt_out;
    logic                r_parity_ok;
    logic                r_len_err;
    logic                r_line_err;
    logic                r_frame_valid;
    logic                r_overrun;

    int   w_n;
    logic w_par_hi;
    logic w_par_lo;
    logic w_parity_ok;

    wiegand_line_filter #(.FILT_CYC(c_filt_cyc)) u_filt_d0 (
        .clk       (clk),
        .rst       (rst),
        .line_n    (d0_n),
        .line_low  (w_d0_low),
        .filt_low  (w_d0_filt),
        .pulse_end (w_d0_end)
    );

    wiegand_line_filter #(.FILT_CYC(c_filt_cyc)) u_filt_d1 (
        .clk       (clk),
        .rst       (rst),
        .line_n    (d1_n),
        .line_low  (w_d1_low),
        .filt_low  (w_d1_filt),
        .pulse_end (w_d1_end)
    );

    assign w_any_low   = w_d0_low | w_d1_low;
    assign w_both_low  = w_d0_low & w_d1_low;
    assign w_all_high  = ~w_any_low;
    assign w_pulse_end = (w_d0_end | w_d1_end) & w_all_high;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_low) w_state_nxt = LOW;
            end
            LOW: begin
                w_latch = !r_latched && !r_ignore && !w_both_low && (w_d0_filt || w_d1_filt);
                if (w_pulse_end) begin
                    w_shift = r_latched && !r_ignore;
                    // A glitch before any real bit is not a frame unless it flagged a line error.
                    w_state_nxt = (w_shift || (r_bit_cnt != 7'd0) || r_line_err_acc) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (w_any_low) begin
                    w_state_nxt = LOW;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Leading half even, trailing half odd; only meaningful for even 4..MAX_BITS.
    always_comb begin
        w_par_hi = 1'b0;
        w_par_lo = 1'b0;
        w_n      = int'(r_bit_cnt);
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < w_n / 2) begin
                w_par_lo = w_par_lo ^ r_buf[i];
            end else if (i < w_n) begin
                w_par_hi = w_par_hi ^ r_buf[i];
            end
        end
        if (PARITY_EN == 0) begin
            w_parity_ok = 1'b1;
        end else begin
            w_parity_ok = !r_bit_cnt[0] && (r_bit_cnt >= 7'd4) && (r_bit_cnt <= c_max_cnt)
                          && !w_par_hi && w_par_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt       <= '0;
            r_latched      <= 1'b0;
            r_bit          <= 1'b0;
            r_ignore       <= 1'b0;
            r_buf          <= '0;
            r_bit_cnt      <= '0;
            r_len_over     <= 1'b0;
            r_line_err_acc <= 1'b0;
            r_data         <= '0;
            r_cnt_out      <= '0;
            r_parity_ok    <= 1'b0;
            r_len_err      <= 1'b0;
            r_line_err     <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == GAP && !w_any_low) ? r_to_cnt + 1'b1 : '0;

            if (w_latch) begin
                r_latched <= 1'b1;
                r_bit     <= w_d1_filt;
            end else if (w_pulse_end) begin
                r_latched <= 1'b0;
            end

            if (w_both_low) begin
                r_ignore <= 1'b1;
            end else if (w_all_high) begin
                r_ignore <= 1'b0;
            end

            if (w_shift) begin
                if (r_bit_cnt < c_max_cnt) begin
                    r_buf <= {r_buf[MAX_BITS-2:0], r_bit};
                end else begin
                    r_len_over <= 1'b1;
                end
                if (r_bit_cnt != c_cnt_sat) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_both_low) begin
                r_line_err_acc <= 1'b1;
            end

            if (r_state == DONE) begin
                r_buf          <= '0;
                r_bit_cnt      <= '0;
                r_len_over     <= 1'b0;
                r_line_err_acc <= w_both_low;
                // A same-cycle ack frees the slot, so the new frame replaces the old one.
                if (!r_frame_valid || bus.frame_ack) begin
                    r_data        <= r_buf;
                    r_cnt_out     <= r_bit_cnt;
                    r_parity_ok   <= w_parity_ok;
                    r_len_err     <= r_len_over || (r_bit_cnt < c_min_cnt);
                    r_line_err    <= r_line_err_acc;
                    r_frame_valid <= 1'b1;
                    r_overrun     <= 1'b0;
                end else begin
                    r_overrun     <= 1'b1;
                end
            end else if (bus.frame_ack && r_frame_valid) begin
                r_frame_valid <= 1'b0;
                r_overrun     <= 1'b0;
            end
        end
    end

    assign bus.data        = r_data;
    assign bus.bit_cnt     = r_cnt_out;
    assign bus.frame_valid = r_frame_valid;
    assign bus.parity_ok   = r_parity_ok;
    assign bus.len_err     = r_len_err;
    assign bus.line_err    = r_line_err;
    assign bus.overrun     = r_overrun;
    assign bus.busy        = (r_state == LOW) || (r_state == GAP);

endmodule
`default_nettype wire

// File: tb/tb_wiegand_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_wiegand_rx_param
// Brief    : Scoreboard testbench for wiegand_rx_param
// Revision : 1.0 - initial release
// ============================================================================
module tb_wiegand_rx_param;
    import wiegand_pkg::*;

    localparam int CLK_HZ = 1000000;
    localparam int MAXB   = W34;
    localparam int MINB   = W26;
    localparam int FILT   = 20;
    localparam int TO_US  = 200;
    localparam int TO_CYC = TO_US;
    // Two synchroniser stages between the line and the filtered pulse end.
    localparam int LAT    = TO_CYC + 2 + 2;
    localparam int PULSE  = 30;
    localparam int GAPC   = 60;

    typedef struct {
        logic [MAXB-1:0] data;
        logic [6:0]      cnt;
        logic            par;
        logic            len;
        logic            line;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic d0_n = 1'b1;
    logic d1_n = 1'b1;
    int   cyc  = 0;
    int   t_end = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wiegand_rx_param_if #(.MAX_BITS(MAXB)) bus ();

    wiegand_rx_param #(
        .CLK_HZ     (CLK_HZ),
        .MAX_BITS   (MAXB),
        .MIN_BITS   (MINB),
        .FILT_US    (FILT),
        .TIMEOUT_US (TO_US),
        .PARITY_EN  (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d0_n (d0_n),
        .d1_n (d1_n),
        .bus  (bus)
    );

    function automatic logic [63:0] mk_frame(input logic [63:0] payload, input int n);
        logic [63:0] f;
        logic        pe;
        logic        po;
        f  = (payload << 1) & ((64'd1 << n) - 64'd1);
        pe = 1'b0;
        for (int i = n / 2; i <= n - 2; i++) pe = pe ^ f[i];
        po = 1'b1;
        for (int i = 1; i < n / 2; i++) po = po ^ f[i];
        f[n-1] = pe;
        f[0]   = po;
        return f;
    endfunction

    function automatic exp_t model(input logic [63:0] f, input int n, input logic line);
        exp_t        e;
        logic [63:0] t;
        int          hi;
        int          lo;
        t      = (n > MAXB) ? (f >> (n - MAXB)) : f;
        e.data = t[MAXB-1:0];
        e.cnt  = 7'((n > MAXB) ? MAXB + 1 : n);
        e.len  = (n < MINB) || (n > MAXB);
        e.line = line;
        hi = 0;
        lo = 0;
        for (int i = 0; i < n && i < 64; i++) begin
            if (f[i]) begin
                if (i >= n / 2) hi++;
                else lo++;
            end
        end
        e.par = (n % 2 == 0) && (n >= 4) && (n <= MAXB) && (hi % 2 == 0) && (lo % 2 == 1);
        return e;
    endfunction

    task automatic send_frame(input logic [63:0] f, input int n, input bit glitch,
                              input int both_at, input bit publish);
        if (publish) sb.push_back(model(f, n, both_at >= 0));
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            if (f[i]) d1_n = 1'b0;
            else d0_n = 1'b0;
            repeat (PULSE) @(negedge clk);
            d0_n  = 1'b1;
            d1_n  = 1'b1;
            t_end = cyc;
            if (i != 0) begin
                if (glitch) begin
                    repeat (20) @(negedge clk);
                    d0_n = 1'b0;
                    repeat (5) @(negedge clk);
                    d0_n = 1'b1;
                    repeat (GAPC - 25) @(negedge clk);
                end else begin
                    repeat (GAPC) @(negedge clk);
                end
                if (i == both_at) begin
                    d0_n = 1'b0;
                    d1_n = 1'b0;
                    repeat (PULSE) @(negedge clk);
                    d0_n = 1'b1;
                    d1_n = 1'b1;
                    repeat (GAPC) @(negedge clk);
                end
            end
        end
    endtask

    task automatic wait_frame(input string name, input bit do_ack);
        exp_t e;
        int   waited;
        waited = 0;
        while (bus.frame_valid !== 1'b1 && waited < LAT + 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (bus.frame_valid !== 1'b1) begin
            $display("FAIL %s valid_timeout: frame_valid=%b required 1", name, bus.frame_valid);
            n_errors++;
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s unexpected_frame: scoreboard empty, data=%h", name, bus.data);
            n_errors++;
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc - t_end !== LAT) begin
            $display("FAIL %s latency: got %0d cycles required %0d", name, cyc - t_end, LAT);
            n_errors++;
        end
        n_checks++;
        if (bus.data !== e.data) begin
            $display("FAIL %s data: got %h required %h", name, bus.data, e.data);
            n_errors++;
        end
        n_checks++;
        if (bus.bit_cnt !== e.cnt) begin
            $display("FAIL %s bit_cnt: got %0d required %0d", name, bus.bit_cnt, e.cnt);
            n_errors++;
        end
        n_checks++;
        if (bus.parity_ok !== e.par) begin
            $display("FAIL %s parity_ok: got %b required %b", name, bus.parity_ok, e.par);
            n_errors++;
        end
        n_checks++;
        if (bus.len_err !== e.len) begin
            $display("FAIL %s len_err: got %b required %b", name, bus.len_err, e.len);
            n_errors++;
        end
        n_checks++;
        if (bus.line_err !== e.line) begin
            $display("FAIL %s line_err: got %b required %b", name, bus.line_err, e.line);
            n_errors++;
        end
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            $display("FAIL %s overrun: got %b required 0", name, bus.overrun);
            n_errors++;
        end
        if (do_ack) begin
            bus.frame_ack = 1'b1;
            @(negedge clk);
            bus.frame_ack = 1'b0;
            n_checks++;
            if (bus.frame_valid !== 1'b0) begin
                $display("FAIL %s ack_clear: frame_valid=%b required 0", name, bus.frame_valid);
                n_errors++;
            end
            n_checks++;
            if (bus.data !== e.data) begin
                $display("FAIL %s data_held: got %h required %h", name, bus.data, e.data);
                n_errors++;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({bus.data, bus.bit_cnt, bus.frame_valid, bus.parity_ok, bus.len_err,
             bus.line_err, bus.overrun, bus.busy} !== '0) begin
            $display("FAIL %s outputs: data=%h cnt=%0d valid=%b par=%b len=%b line=%b ovr=%b busy=%b required all 0",
                     name, bus.data, bus.bit_cnt, bus.frame_valid, bus.parity_ok, bus.len_err,
                     bus.line_err, bus.overrun, bus.busy);
            n_errors++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_active");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_basic();
        send_frame(64'h2A55A5A, W26, 1'b0, -1, 1'b1);
        wait_frame("basic26", 1'b1);
    endtask

    task automatic test_parity_flip();
        send_frame(64'h2A55A5A ^ (64'd1 << 25), W26, 1'b0, -1, 1'b1);
        wait_frame("parity_flip", 1'b1);
    endtask

    task automatic test_lengths();
        send_frame(mk_frame(64'h12345678, W34), W34, 1'b0, -1, 1'b1);
        wait_frame("frame34", 1'b1);
        send_frame(64'h9ABCDEF01, 36, 1'b0, -1, 1'b1);
        wait_frame("pulses36", 1'b1);
    endtask

    task automatic test_glitch();
        send_frame(64'h2A55A5A, W26, 1'b1, -1, 1'b1);
        wait_frame("glitch26", 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [63:0] fa;
        logic [63:0] fb;
        fa = mk_frame(64'hABCDE1, W26);
        fb = mk_frame(64'h123456, W26);
        send_frame(fa, W26, 1'b0, -1, 1'b1);
        wait_frame("overrun_first", 1'b0);
        send_frame(fb, W26, 1'b0, -1, 1'b0);
        repeat (LAT + 20) @(negedge clk);
        n_checks++;
        if (bus.overrun !== 1'b1 || bus.frame_valid !== 1'b1) begin
            $display("FAIL overrun_set: overrun=%b valid=%b required 1 1", bus.overrun, bus.frame_valid);
            n_errors++;
        end
        n_checks++;
        if (bus.data !== fa[MAXB-1:0]) begin
            $display("FAIL overrun_data: got %h required %h", bus.data, fa[MAXB-1:0]);
            n_errors++;
        end
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        n_checks++;
        if (bus.overrun !== 1'b0 || bus.frame_valid !== 1'b0) begin
            $display("FAIL overrun_ack: overrun=%b valid=%b required 0 0", bus.overrun, bus.frame_valid);
            n_errors++;
        end
    endtask

    task automatic test_line_err_reset();
        send_frame(64'h2A55A5A, W26, 1'b0, 13, 1'b1);
        wait_frame("line_err", 1'b1);
        send_frame(64'h2A5, 10, 1'b0, -1, 1'b0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL busy_midframe: got %b required 1", bus.busy);
            n_errors++;
        end
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_midframe");
        repeat (LAT + 20) @(negedge clk);
        n_checks++;
        if (bus.frame_valid !== 1'b0) begin
            $display("FAIL partial_discarded: frame_valid=%b required 0", bus.frame_valid);
            n_errors++;
        end
        send_frame(mk_frame(64'h5A5A5A, W26), W26, 1'b0, -1, 1'b1);
        wait_frame("after_reset", 1'b1);
    endtask

    initial begin
        bus.frame_ack = 1'b0;
        test_reset();
        test_basic();
        test_parity_flip();
        test_lengths();
        test_glitch();
        test_back_to_back();
        test_line_err_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/wiegand_rx_param.md
Name: wiegand_rx_param

Overview:
Parametrised Wiegand reader input for the access-control FPGA, replacing the fixed 26-bit receiver. It synchronises and glitch-filters the D0/D1 lines, counts frames of any length up to MAX_BITS, terminates frames on an inter-bit timeout derived from CLK_HZ, and checks standard Wiegand parity. Completed frames are presented to the CPU bus interface with a valid/ack handshake and status flags. Everything runs on clk; there is no clock derived from the Wiegand lines.

Parameters:
CLK_HZ, 1000000, system clock frequency in Hz
MAX_BITS, 34, data register width and longest frame accepted (even, 4..64)
MIN_BITS, 26, shortest frame accepted without length error
FILT_US, 20, minimum low-pulse width in µs; shorter pulses are ignored
TIMEOUT_US, 5000, idle gap in µs that ends a frame
PARITY_EN, 1, 1 = check leading-even/trailing-odd parity; 0 = parity_ok forced 1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
d0_n  in  1  Wiegand DATA0, idle high, low pulse = bit 0 (asynchronous)
d1_n  in  1  Wiegand DATA1, idle high, low pulse = bit 1 (asynchronous)
data  out  MAX_BITS  frame bits, right-aligned, last-received bit at data[0]
bit_cnt  out  7  number of bits in the presented frame
frame_valid  out  1  frame presented; held until frame_ack
frame_ack  in  1  one-cycle acknowledge from the bus interface
parity_ok  out  1  parity result for the presented frame
len_err  out  1  bit_cnt < MIN_BITS or more than MAX_BITS pulses received
line_err  out  1  both lines were low simultaneously during the frame
overrun  out  1  a frame completed while frame_valid was high; sticky until ack
busy  out  1  a frame is being received

Behaviour:
- Reset: all outputs 0; shift register, counters and flags 0; FSM in IDLE; synchroniser flops 1.
- Input path: 2-flop synchroniser per line. Filter counter FILT_CYC = CLK_HZ/1e6*FILT_US (minimum 1) counts while a single synchronised line stays low.
- FSM states:
  - IDLE: wait for a line to go low.
  - LOW: one line is low.
    - If the filter count reaches FILT_CYC, latch the bit value (d1 low = 1).
    - On return high: if the bit was latched, shift it in and go to GAP; otherwise go back to GAP/IDLE without shifting (glitch).
  - GAP: timeout counter TO_CYC = CLK_HZ/1e6*TIMEOUT_US. It is reset by a new low, which moves the FSM to LOW. On reaching TO_CYC, go to DONE.
  - DONE: one cycle. Load the outputs, then return to IDLE.
- Both lines low in any state: set internal line_err, and ignore the pulse until both lines are high again.
- Shift: buf <= {buf[MAX_BITS-2:0], bit}. Bit count saturates at MAX_BITS+1. Pulses beyond MAX_BITS do not shift and set len_err.
- Parity for a frame of N bits, with b[N-1] first received:
  - Even parity over b[N-1 : N/2].
  - Odd parity over b[N/2-1 : 0].
  - Odd N, or N < 4, gives parity_ok = 0.
- Publish in DONE:
  - If frame_valid = 0: data, bit_cnt, parity_ok, len_err and line_err load; frame_valid <= 1.
  - If frame_valid = 1: the new frame is dropped and overrun <= 1.
- Latency: frame_valid rises TO_CYC + 2 cycles after the filtered end of the last pulse.
- Handshake: frame_ack while frame_valid = 1 clears frame_valid and overrun on the next cycle; data is held. frame_ack while frame_valid = 0 is ignored.
- DONE and frame_ack in the same cycle: the ack clears the old frame and the new frame loads. frame_valid stays 1 and overrun is not set.
- busy = 1 in LOW and GAP.
- An asynchronous reset mid-frame discards the partial frame.
- Counter widths come from $clog2 of the computed cycle constants.

Decomposition:
- Shared package wiegand_pkg:
  - Frame-length constants: W26 = 26, W34 = 34.
  - FSM state enum: IDLE, LOW, GAP, DONE.
  - us_to_cycles() function.
- One sub-module, wiegand_line_filter: synchroniser plus glitch filter for one line. It is instantiated twice and outputs a filtered low level and a pulse-end strobe.

Test Plan:
- 26-bit frame 0x2A5_5A5A with correct parity, 50 µs pulses and 2 ms gaps, CLK_HZ = 1 MHz -> frame_valid after 5 ms idle; data = 0x2A55A5A, bit_cnt = 26, parity_ok = 1, len_err = 0.
- Same frame with the leading parity bit flipped -> parity_ok = 0, data shows the flipped MSB.
- 34-bit frame with valid parity -> bit_cnt = 34, parity_ok = 1. A 36-pulse frame -> len_err = 1, bit_cnt = 35.
- 5 µs glitches on d0_n between real bits of a 26-bit frame -> ignored; result identical to the clean frame.
- Second frame completes before any ack -> overrun = 1, data unchanged. Then frame_ack -> frame_valid = 0 and overrun = 0.
- d0_n and d1_n held low together mid-frame, then rst asserted during a later frame -> line_err = 1 reported for the first frame; after reset all outputs are 0 and the next clean frame decodes correctly.
